// File: rtl/paddle_ctl.sv
// Frame-synchronous paddle controller: decodes up/down requests once per frame,
// accelerates while a direction is held, and clamps ypos to [YMIN, YMAX].
module paddle_ctl #(
    parameter int unsigned YMIN         = 16,
    parameter int unsigned YMAX         = 400,
    parameter int unsigned Y_INIT       = 208,
    parameter int unsigned SPEED_MIN    = 1,
    parameter int unsigned SPEED_MAX    = 8,
    parameter int unsigned ACCEL_FRAMES = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       frame,
    input  logic       up,
    input  logic       down,
    output logic [9:0] ypos,
    output logic [3:0] speed,
    output logic       moving,
    output logic       hit_edge
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVE_UP   = 2'd1,
        MOVE_DOWN = 2'd2
    } state_t;

    localparam int unsigned CW = (ACCEL_FRAMES > 1) ? $clog2(ACCEL_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(ACCEL_FRAMES - 1);
    localparam logic [10:0]   YMIN_W   = 11'(YMIN);
    localparam logic [10:0]   YMAX_W   = 11'(YMAX);
    localparam logic [9:0]    YMIN_10  = 10'(YMIN);
    localparam logic [9:0]    YMAX_10  = 10'(YMAX);
    localparam logic [9:0]    YINIT_10 = 10'(Y_INIT);
    localparam logic [3:0]    SMIN_4   = 4'(SPEED_MIN);
    localparam logic [3:0]    SMAX_4   = 4'(SPEED_MAX);

    state_t        state_q, state_d;
    logic [9:0]    ypos_q, ypos_d;
    logic [3:0]    speed_q, speed_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          moving_q, moving_d;
    logic          hit_q, hit_d;

    logic          req_up, req_down;
    logic [3:0]    spd_next;
    logic [10:0]   y_w, spd_w;

    assign req_up   = up & ~down;
    assign req_down = down & ~up;
    assign y_w      = {1'b0, ypos_q};
    assign spd_w    = {7'b0, spd_next};

    // NOTE: every _d gets a default before any branch, so no path leaves a latch.
    always_comb begin
        state_d  = state_q;
        ypos_d   = ypos_q;
        speed_d  = speed_q;
        cnt_d    = cnt_q;
        moving_d = moving_q;
        hit_d    = 1'b0;
        spd_next = speed_q;

        if (frame) begin
            if (!req_up && !req_down) begin
                state_d  = IDLE;
                speed_d  = 4'd0;
                cnt_d    = '0;
                moving_d = 1'b0;
            end else begin
                if ((req_up && state_q == MOVE_UP) || (req_down && state_q == MOVE_DOWN)) begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d    = '0;
                        spd_next = (speed_q >= SMAX_4) ? SMAX_4 : speed_q + 4'd1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else begin
                    state_d  = req_up ? MOVE_UP : MOVE_DOWN;
                    spd_next = SMIN_4;
                    cnt_d    = '0;
                end
                speed_d  = spd_next;
                moving_d = 1'b1;

                // Bounds are checked in 11 bits so neither direction can wrap.
                if (req_up) begin
                    if (y_w < YMIN_W + spd_w) begin
                        ypos_d = YMIN_10;
                        hit_d  = 1'b1;
                    end else begin
                        ypos_d = ypos_q - {6'b0, spd_next};
                    end
                end else begin
                    if (y_w + spd_w > YMAX_W) begin
                        ypos_d = YMAX_10;
                        hit_d  = 1'b1;
                    end else begin
                        ypos_d = ypos_q + {6'b0, spd_next};
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so all of them sample the same edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            ypos_q   <= YINIT_10;
            speed_q  <= 4'd0;
            cnt_q    <= '0;
            moving_q <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ypos_q   <= ypos_d;
            speed_q  <= speed_d;
            cnt_q    <= cnt_d;
            moving_q <= moving_d;
            hit_q    <= hit_d;
        end
    end

    assign ypos     = ypos_q;
    assign speed    = speed_q;
    assign moving   = moving_q;
    assign hit_edge = hit_q;

endmodule

// File: tb/tb_paddle_ctl.sv
// Directed self-checking bench for paddle_ctl at default parameters.
module tb_paddle_ctl;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       frame = 1'b0;
    logic       up = 1'b0;
    logic       down = 1'b0;
    logic [9:0] ypos;
    logic [3:0] speed;
    logic       moving;
    logic       hit_edge;

    int n_cmp = 0;
    int n_bad = 0;

    paddle_ctl dut (
        .clk     (clk),
        .reset_n (reset_n),
        .frame   (frame),
        .up      (up),
        .down    (down),
        .ypos    (ypos),
        .speed   (speed),
        .moving  (moving),
        .hit_edge(hit_edge)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        frame = 1'b0; up = 1'b0; down = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // One frame strobe; returns on the following negedge, where outputs are sampled.
    task automatic step_frame(input logic u, input logic d);
        @(negedge clk);
        frame = 1'b1; up = u; down = d;
        @(negedge clk);
        frame = 1'b0; up = 1'b0; down = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ypos, speed, moving, hit_edge} !== {10'd208, 4'd0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL reset_idle cyc%0d: got y=%0d s=%0d m=%b h=%b want y=208 s=0 m=0 h=0",
                         i, ypos, speed, moving, hit_edge);
            end
        end
    endtask

    task automatic test_accel_up();
        logic [9:0] exp_y [5] = '{10'd207, 10'd206, 10'd205, 10'd204, 10'd202};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step_frame(1'b1, 1'b0);
            n_cmp++;
            if (ypos !== exp_y[i]) begin
                n_bad++;
                $display("FAIL accel_up frame%0d: got ypos=%0d want %0d", i + 1, ypos, exp_y[i]);
            end
        end
        n_cmp++;
        if (speed !== 4'd2 || moving !== 1'b1) begin
            n_bad++;
            $display("FAIL accel_up_final: got s=%0d m=%b want s=2 m=1", speed, moving);
        end
    endtask

    task automatic test_reverse();
        do_reset();
        repeat (9) step_frame(1'b0, 1'b1);
        n_cmp++;
        if (speed !== 4'd3 || ypos !== 10'd223) begin
            n_bad++;
            $display("FAIL reverse_pre: got s=%0d y=%0d want s=3 y=223", speed, ypos);
        end
        step_frame(1'b1, 1'b0);
        n_cmp++;
        if (speed !== 4'd1 || ypos !== 10'd222 || moving !== 1'b1) begin
            n_bad++;
            $display("FAIL reverse_up: got s=%0d y=%0d m=%b want s=1 y=222 m=1", speed, ypos, moving);
        end
    endtask

    task automatic test_clamp_bottom();
        do_reset();
        repeat (28) step_frame(1'b0, 1'b1);
        n_cmp++;
        if (ypos !== 10'd320 || speed !== 4'd7) begin
            n_bad++;
            $display("FAIL down_run28: got y=%0d s=%0d want y=320 s=7", ypos, speed);
        end
        step_frame(1'b0, 1'b0);
        repeat (17) step_frame(1'b0, 1'b1);
        step_frame(1'b0, 1'b0);
        step_frame(1'b0, 1'b1);
        step_frame(1'b0, 1'b0);
        n_cmp++;
        if (ypos !== 10'd366 || speed !== 4'd0 || moving !== 1'b0) begin
            n_bad++;
            $display("FAIL down_setup: got y=%0d s=%0d m=%b want y=366 s=0 m=0", ypos, speed, moving);
        end
        repeat (14) step_frame(1'b0, 1'b1);
        n_cmp++;
        if (ypos !== 10'd398 || speed !== 4'd4 || hit_edge !== 1'b0) begin
            n_bad++;
            $display("FAIL down_398: got y=%0d s=%0d h=%b want y=398 s=4 h=0", ypos, speed, hit_edge);
        end
        step_frame(1'b0, 1'b1);
        n_cmp++;
        if (ypos !== 10'd400 || hit_edge !== 1'b1 || moving !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_max1: got y=%0d h=%b m=%b want y=400 h=1 m=1", ypos, hit_edge, moving);
        end
        @(negedge clk);
        n_cmp++;
        if (hit_edge !== 1'b0) begin
            n_bad++;
            $display("FAIL hit_one_cycle: got h=%b want h=0", hit_edge);
        end
        step_frame(1'b0, 1'b1);
        n_cmp++;
        if (ypos !== 10'd400 || hit_edge !== 1'b1 || speed !== 4'd4) begin
            n_bad++;
            $display("FAIL clamp_max2: got y=%0d h=%b s=%0d want y=400 h=1 s=4", ypos, hit_edge, speed);
        end
        step_frame(1'b1, 1'b1);
        n_cmp++;
        if ({ypos, speed, moving, hit_edge} !== {10'd400, 4'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL both_pressed: got y=%0d s=%0d m=%b h=%b want y=400 s=0 m=0 h=0",
                     ypos, speed, moving, hit_edge);
        end
    endtask

    task automatic test_no_frame_toggle();
        do_reset();
        step_frame(1'b1, 1'b0);
        step_frame(1'b1, 1'b0);
        for (int i = 0; i < 50; i++) begin
            up = i[0];
            down = i[1];
            @(negedge clk);
            n_cmp++;
            if ({ypos, speed, moving, hit_edge} !== {10'd206, 4'd1, 1'b1, 1'b0}) begin
                n_bad++;
                $display("FAIL no_frame cyc%0d: got y=%0d s=%0d m=%b h=%b want y=206 s=1 m=1 h=0",
                         i, ypos, speed, moving, hit_edge);
            end
        end
        step_frame(1'b1, 1'b0);
        step_frame(1'b1, 1'b0);
        n_cmp++;
        if (ypos !== 10'd204 || speed !== 4'd1) begin
            n_bad++;
            $display("FAIL no_frame_resume: got y=%0d s=%0d want y=204 s=1", ypos, speed);
        end
        step_frame(1'b1, 1'b0);
        n_cmp++;
        if (ypos !== 10'd202 || speed !== 4'd2) begin
            n_bad++;
            $display("FAIL no_frame_accel: got y=%0d s=%0d want y=202 s=2", ypos, speed);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        @(negedge clk);
        frame = 1'b1; down = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (ypos !== 10'd209) begin
            n_bad++;
            $display("FAIL b2b_first: got y=%0d want 209", ypos);
        end
        @(negedge clk);
        frame = 1'b0; down = 1'b0;
        n_cmp++;
        if (ypos !== 10'd210 || speed !== 4'd1) begin
            n_bad++;
            $display("FAIL b2b_second: got y=%0d s=%0d want y=210 s=1", ypos, speed);
        end
    endtask

    task automatic test_speed_cap_top();
        do_reset();
        repeat (36) step_frame(1'b1, 1'b0);
        n_cmp++;
        if (ypos !== 10'd32 || speed !== 4'd8) begin
            n_bad++;
            $display("FAIL cap_36: got y=%0d s=%0d want y=32 s=8", ypos, speed);
        end
        step_frame(1'b1, 1'b0);
        step_frame(1'b1, 1'b0);
        n_cmp++;
        if (ypos !== 10'd16 || hit_edge !== 1'b0) begin
            n_bad++;
            $display("FAIL exact_min: got y=%0d h=%b want y=16 h=0", ypos, hit_edge);
        end
        step_frame(1'b1, 1'b0);
        n_cmp++;
        if (ypos !== 10'd16 || hit_edge !== 1'b1 || speed !== 4'd8 || moving !== 1'b1) begin
            n_bad++;
            $display("FAIL clamp_min: got y=%0d h=%b s=%0d m=%b want y=16 h=1 s=8 m=1",
                     ypos, hit_edge, speed, moving);
        end
    endtask

    task automatic test_async_reset();
        // Entered at the negedge where hit_edge=1 after a clamped up move.
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({ypos, speed, moving, hit_edge} !== {10'd208, 4'd0, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL async_reset: got y=%0d s=%0d m=%b h=%b want y=208 s=0 m=0 h=0",
                     ypos, speed, moving, hit_edge);
        end
        @(negedge clk);
        reset_n = 1'b1;
        step_frame(1'b1, 1'b0);
        n_cmp++;
        if (ypos !== 10'd207 || speed !== 4'd1 || moving !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_move: got y=%0d s=%0d m=%b want y=207 s=1 m=1",
                     ypos, speed, moving);
        end
    endtask

    initial begin
        test_reset();
        test_accel_up();
        test_reverse();
        test_clamp_bottom();
        test_no_frame_toggle();
        test_back_to_back();
        test_speed_cap_top();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
